// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared widths, frame lengths and shift-path state type for the deserializer
package deserializer_pkg;

  localparam int DATA_W           = 16;
  localparam int CNT_W            = 5;
  localparam int FRAME_LEN_PLAIN  = DATA_W;
  localparam int FRAME_LEN_PARITY = DATA_W + 1;

  typedef enum logic {
    COLLECT  = 1'b0,
    COMPLETE = 1'b1
  } shift_state_e;

  function automatic int frame_len(input int n, input bit parity_en);
    return parity_en ? n + 2 : n + 1;
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// rtl/deser_bit_counter.sv - frame bit counter with frame_start reload and wrap after the last bit
module deser_bit_counter
  import deserializer_pkg::*;
#(
  parameter int CW   = CNT_W,
  parameter int LAST = FRAME_LEN_PLAIN - 1
) (
  input  logic          clk,
  input  logic          init,
  input  logic          bit_valid,
  input  logic          frame_start,
  output logic [CW-1:0] count,
  output logic          at_last
);

  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (bit_valid) begin
      if (frame_start) begin
        // The frame_start bit is bit 0, so the next expected position is 1.
        count_d = CW'(1);
      end else if (count_q == LAST_C) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == LAST_C);

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - LSB-first serial-to-parallel converter; DESERIALIZER_PARITY_EN adds an even-parity bit per frame
module deserializer
  import deserializer_pkg::*;
#(
  parameter int N = DATA_W - 1
) (
  input  logic       clk,
  input  logic       init,
  input  logic       data_in,
  input  logic       bit_valid,
  input  logic       frame_start,
  input  logic       data_ack,
  output logic [N:0] data_out,
  output logic       data_valid,
  output logic       overrun,
  output logic       parity_err
);

`ifdef DESERIALIZER_PARITY_EN
  localparam int FRAME = frame_len(N, 1'b1);
`else
  localparam int FRAME = frame_len(N, 1'b0);
`endif
  localparam int LAST = FRAME - 1;
  localparam int CW   = ($clog2(FRAME) > CNT_W) ? $clog2(FRAME) : CNT_W;

  logic [CW-1:0] count;
  logic          at_last;
  shift_state_e  shift_state;
  logic          complete;

  logic [N:0] shift_q, shift_d;
  logic [N:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       overrun_q, overrun_d;

  deser_bit_counter #(
    .CW   (CW),
    .LAST (LAST)
  ) u_bit_counter (
    .clk         (clk),
    .init        (init),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .count       (count),
    .at_last     (at_last)
  );

  always_comb begin
    shift_state = at_last ? COMPLETE : COLLECT;
    // frame_start outranks completion even on the last bit position.
    complete    = bit_valid && !frame_start && (shift_state == COMPLETE);
  end

  always_comb begin
    shift_d = shift_q;
    if (bit_valid) begin
      if (frame_start) begin
        shift_d    = '0;
        shift_d[0] = data_in;
      end else begin
        // The parity position lies beyond N and matches no data index.
        for (int i = 0; i <= N; i++) begin
          if (count == CW'(i)) begin
            shift_d[i] = data_in;
          end
        end
      end
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    if (complete) begin
      data_out_d   = shift_d;
      data_valid_d = 1'b1;
      if (data_valid_q && !data_ack) begin
        overrun_d = 1'b1;
      end
    end else if (data_ack) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef DESERIALIZER_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q;
    if (complete) begin
      parity_err_d = (^shift_d) ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - randomized bench for deserializer against a queue-based frame model
module tb_deserializer;

  localparam int N = 15;
`ifdef DESERIALIZER_PARITY_EN
  localparam int FRAME = N + 2;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = N + 1;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       data_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       data_ack = 1'b0;
  logic [N:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       parity_err;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  bit         m_bits[$];
  logic [N:0] m_data  = '0;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_perr  = 1'b0;

  deserializer #(.N(N)) dut (
    .clk         (clk),
    .init        (init),
    .data_in     (data_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: collect accepted bits in a queue, emit a word when the queue reaches a frame.
  task automatic model_step(input bit ini, input bit bv, input bit fs, input bit din, input bit ack);
    logic [N:0] w;
    bit p;
    bit done;
    w = '0;
    p = 1'b0;
    done = 1'b0;
    if (ini) begin
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      return;
    end
    if (bv) begin
      if (fs) m_bits.delete();
      m_bits.push_back(din);
      if (m_bits.size() == FRAME) begin
        foreach (m_bits[k]) begin
          p ^= m_bits[k];
          if (k <= N) w[k] = m_bits[k];
        end
        done = 1'b1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (m_valid && !ack) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = w;
      m_perr  = PAR ? p : 1'b0;
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input bit ini, input bit bv, input bit fs, input bit din, input bit ack);
    init        = ini;
    bit_valid   = bv;
    frame_start = fs;
    data_in     = din;
    data_ack    = ack;
    @(posedge clk);
    model_step(ini, bv, fs, din, ack);
    #1;
  endtask

  function automatic logic [31:0] frame_of(input logic [N:0] w);
    return PAR ? {15'b0, ^w, w} : {16'b0, w};
  endfunction

  task automatic send(input logic [31:0] f, input int nbits, input bit fs_first, input bit ack_last);
    for (int k = 0; k < nbits; k++) begin
      cyc(1'b0, 1'b1, fs_first && (k == 0), f[k], ack_last && (k == nbits - 1));
    end
  endtask

  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mod_v,
                     input logic [31:0] exp);
    check(name, dut_v, exp);
    check({name, "_model"}, mod_v, exp);
  endtask

  task automatic lit_all(input string tag, input logic [N:0] d, input bit v, input bit o);
    lit({tag, "_data"}, 32'(data_out), 32'(m_data), 32'(d));
    lit({tag, "_valid"}, 32'(data_valid), 32'(m_valid), 32'(v));
    lit({tag, "_overrun"}, 32'(overrun), 32'(m_ovr), 32'(o));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data_out", 32'(data_out), 32'(m_data));
      check("cyc_data_valid", 32'(data_valid), 32'(m_valid));
      check("cyc_overrun", 32'(overrun), 32'(m_ovr));
      check("cyc_parity_err", 32'(parity_err), 32'(m_perr));
    end
  end

  initial begin
    logic [31:0] f;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    lit_all("reset", 16'h0000, 1'b0, 1'b0);
    check("reset_perr", 32'(parity_err), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    f = frame_of(16'h1111);
    send(f, FRAME - 1, 1'b0, 1'b0);
    lit("h1111_before_last_valid", 32'(data_valid), 32'(m_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, f[FRAME-1], 1'b0);
    lit_all("h1111", 16'h1111, 1'b1, 1'b0);

    send(frame_of(16'hA5A5), FRAME, 1'b0, 1'b0);
    lit_all("a5a5_overrun", 16'hA5A5, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit_all("ack_clears_valid", 16'hA5A5, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit_all("ack_idle_no_effect", 16'hA5A5, 1'b0, 1'b1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(frame_of(16'h0F0F), FRAME, 1'b0, 1'b0);
    send(frame_of(16'h00FF), FRAME, 1'b0, 1'b1);
    lit_all("ack_on_completion", 16'h00FF, 1'b1, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(frame_of(16'hFFFF), 7, 1'b1, 1'b0);
    lit("partial_no_valid", 32'(data_valid), 32'(m_valid), 32'd0);
    send(frame_of(16'hBEEF), FRAME, 1'b1, 1'b0);
    lit_all("beef_restart", 16'hBEEF, 1'b1, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(frame_of(16'h1357), FRAME - 1, 1'b1, 1'b0);
    send(frame_of(16'h2468), FRAME, 1'b1, 1'b0);
    lit_all("fs_on_last_position", 16'h2468, 1'b1, 1'b0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(frame_of(16'hFFFF), 9, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    lit_all("init_mid_frame", 16'h0000, 1'b0, 1'b0);
    send(frame_of(16'h1234), FRAME, 1'b0, 1'b0);
    lit_all("h1234_after_init", 16'h1234, 1'b1, 1'b0);

`ifdef DESERIALIZER_PARITY_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send({15'b0, 1'b1, 16'h0001}, FRAME, 1'b0, 1'b0);
    lit("parity_good", 32'(parity_err), 32'(m_perr), 32'd0);
    send({15'b0, 1'b0, 16'h0001}, FRAME, 1'b0, 1'b1);
    lit("parity_bad", 32'(parity_err), 32'(m_perr), 32'd1);
`endif

    for (int c = 0; c < 4000; c++) begin
      cyc($urandom_range(0, 199) == 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
          1'($urandom), ($urandom % 5) == 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
